// File: rtl/fp_mul_arbiter_pkg.sv
// fp_mul_arb_pkg
// Shared constants, types and helpers for the FP multiplier arbiter slice.
//   FP_WORD_W       : width of a single-precision operand/result
//   DEF_NUM_REQ     : default number of requesters
//   DEF_LATENCY     : default multiplier latency in cycles
//   TAG_IDX_W       : tag index width, sized for the largest legal NUM_REQ (16)
//   idx_width(n)    : clog2(n) with a floor of 1
//   tag_t           : {valid, idx} entry travelling alongside each multiply
package fp_mul_arb_pkg;

    localparam int FP_WORD_W   = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 3;
    localparam int TAG_IDX_W   = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The index field is fixed at the widest legal size so the struct does not
    // depend on a module parameter; narrower indices are zero-extended.
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter owning the rotating priority pointer.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req          : request vector (NUM_REQ)
//   advance      : move the pointer past the current winner when a grant occurs
//   grant        : one-hot grant (all zero when nothing requests)
//   grant_idx    : binary index of the winner
//   grant_any    : at least one request was granted
module rr_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Search from ptr upward with wrap; iterating from the far end downward
    // lets the candidate closest to ptr overwrite any later one.
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to one past the winner, wrapping explicitly so that
    // non-power-of-two requester counts stay in range.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_any) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
// Shares one external pipelined FP multiplier among NUM_REQ requesters.
// One operand pair is issued per cycle (round-robin); a tag pipeline of
// LATENCY stages steers each product back to its issuer.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   req_valid / req_ready   : per-requester valid and one-hot grant
//   req_a / req_b           : packed operands, requester i at [32i+31:32i]
//   resp_valid / resp_q     : one-hot result pulse and shared result bus
//   mul_a / mul_b / mul_q   : multiplier operands and result
// Optional (macro FP_MUL_ARB_STATS_EN):
//   stat_issued             : grants issued
//   stat_conflict           : cycles with more than one requester valid
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*FP_WORD_W-1:0] req_a,
    input  logic [NUM_REQ*FP_WORD_W-1:0] req_b,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [FP_WORD_W-1:0]         resp_q,
    output logic [FP_WORD_W-1:0]         mul_a,
    output logic [FP_WORD_W-1:0]         mul_b,
    input  logic [FP_WORD_W-1:0]         mul_q
`ifdef FP_MUL_ARB_STATS_EN
    ,
    output logic [31:0]                  stat_issued,
    output logic [31:0]                  stat_conflict
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] req_gated;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    tag_t               tag_q [LATENCY];
    tag_t               tag_d [LATENCY];
    tag_t               tag_last;

    // Requests are masked during reset so nothing is granted or issued.
    assign req_gated = reset ? '0 : req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_gated),
        .advance   (1'b1),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Operand mux; idle cycles present zeros to the multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant_any) begin
            mul_a = req_a[int'(grant_idx)*FP_WORD_W +: FP_WORD_W];
            mul_b = req_b[int'(grant_idx)*FP_WORD_W +: FP_WORD_W];
        end
    end

    // Tag shift pipeline, free-running in lockstep with the multiplier.
    always_comb begin
        tag_d[0].valid = grant_any;
        tag_d[0].idx   = TAG_IDX_W'(grant_idx);
        for (int k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign tag_last = tag_q[LATENCY-1];

    // Response steering; reset also silences the outputs in the reset cycle
    // so work issued before reset never produces a pulse.
    always_comb begin
        resp_valid = '0;
        resp_q     = '0;
        if (!reset && tag_last.valid) begin
            resp_q = mul_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_valid[i] = (tag_last.idx == TAG_IDX_W'(i));
            end
        end
    end

`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_issued_d;
    logic [31:0] stat_conflict_q;
    logic [31:0] stat_conflict_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stat_issued_d   = stat_issued_q;
        stat_conflict_d = stat_conflict_q;
        if (grant_any) begin
            stat_issued_d = stat_issued_q + 32'd1;
        end
        if ($countones(req_valid) > 1) begin
            stat_conflict_d = stat_conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_issued_q   <= stat_issued_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter
// Directed bench for fp_mul_arbiter with a behavioural multiplier model,
// a reference round-robin model and a response scoreboard.
// Build with FP_MUL_ARB_STATS_EN defined to also exercise the counters.
module tb_fp_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] val;
    } sb_t;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_q;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_q;
`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0]       stat_issued;
    logic [31:0]       stat_conflict;
    int                exp_issued;
    int                exp_conflict;
`endif

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic [31:0] mpipe [LAT];
    sb_t         sbq [$];
    int          m_ptr;
    int          cyc;
    int          n_checks;
    int          n_fail;

    fp_mul_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_q        (resp_q),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_q         (mul_q)
`ifdef FP_MUL_ARB_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Simple normal-number FP32 multiply (truncating), enough for the
    // exact products used here.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, 8'(e), m};
    endfunction

    // Multiplier stand-in with LAT cycles of latency.
    always @(posedge clock) begin
        mpipe[0] <= fp_mul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_q = mpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Compares every output against the reference models, then advances them.
    task automatic checkOutput();
        int          g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        logic [31:0]  exp_q;
        sb_t          e;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("mul_a", mul_a, (g >= 0) ? op_a[g] : 32'd0);
        chk("mul_b", mul_b, (g >= 0) ? op_b[g] : 32'd0);

        exp_rv = '0;
        exp_q  = '0;
        if (reset) begin
            sbq.delete();
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            exp_rv[e.idx] = 1'b1;
            exp_q = e.val;
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_q", resp_q, exp_q);

`ifdef FP_MUL_ARB_STATS_EN
        chk("stat_issued", stat_issued, 32'(exp_issued));
        chk("stat_conflict", stat_conflict, 32'(exp_conflict));
        if (reset) begin
            exp_issued   = 0;
            exp_conflict = 0;
        end else begin
            if (g >= 0) exp_issued++;
            if ($countones(req_valid) > 1) exp_conflict++;
        end
`endif

        if (reset) begin
            m_ptr = 0;
        end else if (g >= 0) begin
            sbq.push_back('{due: cyc + LAT, idx: g, val: fp_mul(op_a[g], op_b[g])});
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] rv, input int n);
        reset     = rst;
        req_valid = rv;
        repeat (n) begin
            @(negedge clock);
            checkOutput();
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_ptr    = 0;
`ifdef FP_MUL_ARB_STATS_EN
        exp_issued   = 0;
        exp_conflict = 0;
`endif
        op_a[0] = 32'h40000000; op_b[0] = 32'h40400000;
        op_a[1] = 32'h3F800000; op_b[1] = 32'h3FC00000;
        op_a[2] = 32'h40400000; op_b[2] = 32'hBF800000;
        op_a[3] = 32'h40800000; op_b[3] = 32'h41200000;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;

        // Reset state, with requests present but ignored.
        applyStimulus(1'b1, 4'b1111, 2);
        applyStimulus(1'b1, 4'b0000, 1);

        // Single 2.0 * 3.0 from requester 0.
        applyStimulus(1'b0, 4'b0000, 2);
        applyStimulus(1'b0, 4'b0001, 1);
        applyStimulus(1'b0, 4'b0000, LAT + 2);
        chk("single_op_resp_q", fp_mul(op_a[0], op_b[0]), 32'h40C00000);

        // All four requesting continuously.
        applyStimulus(1'b0, 4'b1111, 12);
        applyStimulus(1'b0, 4'b0000, LAT + 1);

        // Drive ptr to 3, then wrap between 3 and 0.
        applyStimulus(1'b0, 4'b0100, 1);
        applyStimulus(1'b0, 4'b1001, 3);
        applyStimulus(1'b0, 4'b0000, LAT + 1);

        // Reset with three operations in flight.
        applyStimulus(1'b0, 4'b1111, 3);
        applyStimulus(1'b1, 4'b1111, 1);
        applyStimulus(1'b0, 4'b0110, 1);
        applyStimulus(1'b0, 4'b0000, LAT + 2);
        applyStimulus(1'b0, 4'b1111, 1);
        applyStimulus(1'b0, 4'b0000, LAT + 1);

        // Idle gaps between single operations.
        applyStimulus(1'b0, 4'b0010, 1);
        applyStimulus(1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 4'b1000, 1);
        applyStimulus(1'b0, 4'b0000, LAT + 2);

`ifdef FP_MUL_ARB_STATS_EN
        applyStimulus(1'b1, 4'b0000, 1);
        applyStimulus(1'b0, 4'b1111, 10);
        applyStimulus(1'b0, 4'b0100, 5);
        applyStimulus(1'b0, 4'b0000, LAT + 1);
        chk("stats_issued_total", 32'(exp_issued), 32'd15);
        chk("stats_conflict_total", 32'(exp_conflict), 32'd10);
`endif

        // Random request patterns.
        for (int r = 0; r < 40; r++) begin
            applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1);
        end
        applyStimulus(1'b0, 4'b0000, LAT + 2);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
